pc_gen_unit: RTL

//  Parametrised program-counter generator for the IF stage.

---
 rtl/pc_gen_unit_if.sv | 34 +++
 rtl/pc_gen_unit.sv | 101 ++++++++++
 2 files changed

// File: rtl/pc_gen_unit_if.sv
// Purpose: bundles the PC generator's fetch handshake and redirect sideband into one port.
// Ports:   master = PC generator side (drives pc/valid/redirect/misalign); slave = pipeline side.
// Parameters XLEN / IMM_W must match those of the attached pc_gen_unit.
interface pc_gen_unit_if #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 13
);
    logic             if_ready_i;
    logic             halt_i;
    logic             resume_i;
    logic             trap_i;
    logic             jump_i;
    logic [XLEN-1:0]  jump_tgt_i;
    logic             branch_i;
    logic             cond_i;
    logic [XLEN-1:0]  br_base_i;
    logic [IMM_W-1:0] br_imm_i;
    logic [XLEN-1:0]  pc_o;
    logic             if_valid_o;
    logic             redirect_o;
    logic             misalign_o;

    modport master (
        input  if_ready_i, halt_i, resume_i, trap_i, jump_i, jump_tgt_i,
               branch_i, cond_i, br_base_i, br_imm_i,
        output pc_o, if_valid_o, redirect_o, misalign_o
    );

    modport slave (
        output if_ready_i, halt_i, resume_i, trap_i, jump_i, jump_tgt_i,
               branch_i, cond_i, br_base_i, br_imm_i,
        input  pc_o, if_valid_o, redirect_o, misalign_o
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Purpose: IF-stage program counter; next PC by priority trap > jump > taken branch > sequential.
// Latency: every PC/state update visible one cycle after the causing edge; pc_o is purely registered.
// Backpressure: sequential advance only when if_valid_o & if_ready_i; redirects ignore if_ready_i.
// Ports: clk, rst_n (async active-low), bus (pc_gen_unit_if.master) carrying handshake + redirect inputs
//        and pc_o / if_valid_o / redirect_o / misalign_o outputs.
module pc_gen_unit #(
    parameter int              XLEN      = 32,
    parameter int              IMM_W     = 13,
    parameter int              INC       = 4,
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_gen_unit_if.master bus
);
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            misalign_q, misalign_d;

    logic            br_taken;
    logic            redir;
    logic [XLEN-1:0] redir_tgt;
    logic [XLEN-1:0] br_tgt;
    logic            valid;

    assign valid    = (state_q == ST_RUN);
    assign br_taken = bus.branch_i & bus.cond_i;
    assign redir    = bus.trap_i | bus.jump_i | br_taken;
    assign br_tgt   = bus.br_base_i + {{(XLEN-IMM_W){bus.br_imm_i[IMM_W-1]}}, bus.br_imm_i};

    always_comb begin
        redir_tgt = br_tgt;
        if (bus.trap_i) begin
            redir_tgt = TRAP_VEC;
        end else if (bus.jump_i) begin
            redir_tgt = {bus.jump_tgt_i[XLEN-1:1], 1'b0};
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        misalign_d = 1'b0;

        // Redirects win over everything, in every state, and always land in RUN.
        if (redir) begin
            pc_d       = redir_tgt;
            redirect_d = 1'b1;
            // Alignment is only meaningful for a fixed 4-byte instruction stream.
            misalign_d = (INC == 4) && (redir_tgt[1:0] != 2'b00);
            state_d    = ST_RUN;
        end else begin
            unique case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    // Advance and halt can coincide: the accepted fetch still steps the PC.
                    if (bus.if_ready_i) begin
                        pc_d = pc_q + XLEN'(INC);
                    end
                    if (bus.halt_i) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (bus.resume_i) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
            misalign_q <= misalign_d;
        end
    end

    assign bus.pc_o       = pc_q;
    assign bus.if_valid_o = valid;
    assign bus.redirect_o = redirect_q;
    assign bus.misalign_o = misalign_q;
endmodule
